// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with in-order request tracking and a DEPTH-entry instruction buffer.
// Latency: 1 cycle from response to instr_valid; 0 cycles when FETCH_BYPASS_EN is defined and the buffer is empty.
// Backpressure: requests stall once buffer occupancy + outstanding reaches DEPTH; instr_ready low holds the buffer head.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  // Holds requests off until the first clock edge after reset release.
  logic          run_q;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_dat [DEPTH];
  logic [31:0]   buf_pc  [DEPTH];

  logic          req_fire;
  logic          resp_acc;
  logic          resp_drop;
  logic          resp_use;
  logic          buf_empty;
  logic          bypass;
  logic          push;
  logic          pop_buf;
  logic [CW:0]   in_use;
  logic [31:0]   redir_aligned;

  // Every buffer slot is either occupied or reserved by an in-flight request.
  assign in_use        = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = run_q && !redirect_valid && (in_use < DEPTH_W);
  assign imem_addr     = fetch_pc;
  assign req_fire      = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are protocol violations and ignored.
  assign resp_acc      = imem_resp_valid && (outstanding != '0);
  assign resp_drop     = redirect_valid || (drop_cnt != '0);
  assign resp_use      = resp_acc && !resp_drop;
  assign buf_empty     = (count == '0);
  assign redir_aligned = redirect_pc & ~32'd3;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_use && buf_empty;
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid = !buf_empty || bypass;
  assign pop_buf     = !buf_empty && instr_ready;
  // A bypassed response that decode takes this cycle never touches the buffer.
  assign push        = resp_use && !(bypass && instr_ready);

  // Present the buffer head, or the live response when it is being bypassed.
  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (!buf_empty) begin
      instr    = buf_dat[rd_ptr];
      instr_pc = buf_pc[rd_ptr];
    end else if (bypass) begin
      instr    = imem_resp_data;
      instr_pc = resp_pc;
    end
  end

  // Enable fetching one cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Fetch address: advances on each accepted request, reloads on redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redir_aligned;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // PC tag for the next usable response, kept in step with fetch_pc order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      resp_pc <= redir_aligned;
    end else if (resp_use) begin
      resp_pc <= resp_pc + 32'd4;
    end
  end

  // In-flight request count; a fire and a response in one cycle cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, resp_acc})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Responses still owed to pre-redirect requests are counted down and discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= outstanding - CW'(resp_acc);
    end else if (resp_acc && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // Circular buffer pointers and occupancy; redirect empties the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_buf) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      case ({push, pop_buf})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; contents are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_dat[wr_ptr] <= imem_resp_data;
      buf_pc[wr_ptr]  <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-1 in-order memory model.
// Memory returns addr + 0x13 as the instruction word, so every popped word is predictable from its PC.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge or 1ns after a change.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pop    = 0;
  int          n_fire   = 0;
  int          base;
  logic [31:0] exp_pc;
  logic [31:0] mq [$];
  logic        fire_s;
  logic        take_s;
  logic [31:0] addr_s;
  logic        mem_en;
  logic        got_it;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: sample on the falling edge (pops, fires, response takes), then update the memory model.
  task automatic tick();
    @(negedge clk);
    fire_s = imem_req_valid && imem_req_ready;
    addr_s = imem_addr;
    take_s = imem_resp_valid && (mq.size() > 0);
    if (fire_s) n_fire++;
    if (reset && instr_valid && instr_ready) begin
      check("pop_pc", instr_pc, exp_pc);
      check("pop_dat", instr, exp_pc + 32'h13);
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      mq.delete();
    end else begin
      if (take_s) void'(mq.pop_front());
      if (fire_s) mq.push_back(addr_s);
    end
    if (mem_en && (mq.size() > 0)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mq[0] + 32'h13;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  endtask

  initial begin
    reset           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    mem_en          = 1'b1;
    exp_pc          = 32'h0;

    // Reset state
    tick();
    tick();
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);

    // Release: first request one cycle later, to RESET_PC
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    #1;
    check("rel_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    tick();
    #1;
    check("addr_adv", imem_addr, 32'h4);
`ifdef FETCH_BYPASS_EN
    check("byp_valid", 32'(instr_valid), 32'd1);
    check("byp_instr", instr, 32'h13);
    check("byp_pc", instr_pc, 32'h0);
`else
    check("nobyp_wait", 32'(instr_valid), 32'd0);
    tick();
    #1;
    check("buf_valid", 32'(instr_valid), 32'd1);
    check("buf_instr", instr, 32'h13);
    check("buf_pc", instr_pc, 32'h0);
`endif

    // Steady streaming: one instruction per cycle
    base = n_pop;
    for (int i = 0; i < 12; i++) tick();
    check("stream_rate", 32'(n_pop - base), 32'd12);

    // Redirect in the same cycle as a response and a pop
    instr_ready = 1'b0;
    tick();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    check("redir_blocks_req", 32'(imem_req_valid), 32'd0);
    check("redir_resp_pre", 32'(imem_resp_valid), 32'd1);
    check("redir_pop_pre", 32'(instr_valid), 32'd1);
    tick();
    redirect_valid = 1'b0;
    exp_pc         = 32'h200;
    #1;
    check("flush_empty", 32'(instr_valid), 32'd0);
    check("redir_addr", imem_addr, 32'h200);
    base = n_pop;
    for (int i = 0; i < 6; i++) tick();
    check("redir_resume", 32'(n_pop > base), 32'd1);

    // fetch_pc wraps from 0xFFFF_FFFC to 0
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    exp_pc         = 32'hFFFF_FFFC;
    #1;
    check("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
    check("wrap_req", 32'(imem_req_valid), 32'd1);
    tick();
    #1;
    check("wrap_addr", imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) tick();

    // Reset asserted mid-operation clears outputs immediately
    reset = 1'b0;
    #1;
    check("mid_rst_req", 32'(imem_req_valid), 32'd0);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_pc", instr_pc, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);

    // Backpressure: with decode stalled, exactly DEPTH requests issue
    instr_ready = 1'b0;
    exp_pc      = 32'h0;
    tick();
    tick();
    reset = 1'b1;
    base  = n_fire;
    for (int i = 0; i < 14; i++) tick();
    #1;
    check("bp_fires", 32'(n_fire - base), 32'd4);
    check("bp_req_off", 32'(imem_req_valid), 32'd0);
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_head_pc", instr_pc, 32'h0);
    check("bp_head_dat", instr, 32'h13);
    instr_ready = 1'b1;
    base        = n_pop;
    for (int i = 0; i < 8; i++) tick();
    check("bp_drain", 32'(n_pop - base >= 4), 32'd1);

    // Spurious response with nothing outstanding is ignored
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    mem_en         = 1'b0;
    exp_pc         = 32'h0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0BAD;
    #1;
    check("spur_now", 32'(instr_valid), 32'd0);
    tick();
    #1;
    check("spur_after", 32'(instr_valid), 32'd0);

    // Three outstanding, then redirect to 0x100 (low bits ignored)
    imem_req_ready = 1'b1;
    base           = n_fire;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (n_fire - base >= 3) break;
    end
    imem_req_ready = 1'b0;
    check("three_fired", 32'(n_fire - base), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    imem_req_ready = 1'b1;
    #1;
    check("drop_redir_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    mem_en         = 1'b1;
    exp_pc         = 32'h100;
    #1;
    check("drop_addr", imem_addr, 32'h100);
    check("drop_req", 32'(imem_req_valid), 32'd1);
    got_it = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      #1;
      if (instr_valid) begin
        got_it = 1'b1;
        break;
      end
    end
    check("drop_wait", 32'(got_it), 32'd1);
    check("drop_first_pc", instr_pc, 32'h100);
    check("drop_first_dat", instr, 32'h113);
    for (int i = 0; i < 6; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, sets instruction buffer entries and the maximum number of outstanding requests; it is a power of two, 2 to 16.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port imem_req_valid  output  1  fetch request valid.
REQ-006 Port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 Port imem_addr  output  32  word-aligned fetch address.
REQ-008 Port imem_resp_valid  input  1  in-order response valid; latency at least 1 cycle after request acceptance.
REQ-009 Port imem_resp_data  input  32  instruction word.
REQ-010 Port instr_valid  output  1  buffered instruction available to decode.
REQ-011 Port instr_ready  input  1  decode consumes the instruction this cycle.
REQ-012 Port instr  output  32  instruction word.
REQ-013 Port instr_pc  output  32  PC of instr.
REQ-014 Port redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
REQ-015 Port redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.

Function
REQ-016 A request fires when imem_req_valid and imem_req_ready are both 1; fetch_pc then advances by 4 and wraps modulo 2^32.
REQ-017 imem_req_valid is 1 when (buffer occupancy + outstanding) < DEPTH and redirect_valid is 0, so the buffer never overflows.
REQ-018 imem_addr equals fetch_pc; while imem_req_valid is 1 and not accepted, imem_addr holds stable.
REQ-019 The outstanding counter (width clog2(DEPTH+1)) increments on a fired request, decrements on an accepted response, and holds when both occur in the same cycle.
REQ-020 An accepted, non-dropped response is pushed into the buffer with tag resp_pc; resp_pc then advances by 4.
REQ-021 The buffer is a circular FIFO with wrapping read and write pointers.
REQ-022 instr_valid is 1 whenever the buffer is non-empty; an entry pops when instr_valid and instr_ready are both 1.
REQ-023 A push and a pop in the same cycle when full, or when empty (bypass case, see REQ-031), leaves occupancy consistent and loses no data.
REQ-024 On redirect_valid, the following happen in the same cycle:
- buffer is flushed (any pop that cycle still completes);
- fetch_pc and resp_pc load redirect_pc;
- drop_cnt loads (outstanding minus any response accepted that cycle);
- any response arriving that cycle is discarded.
REQ-025 While drop_cnt > 0, each response is discarded and drop_cnt decrements; discarded responses are never pushed.
REQ-026 A redirect arriving while drop_cnt > 0 reloads drop_cnt per REQ-024; no stale instruction ever reaches instr_valid.
REQ-027 imem_resp_valid with outstanding = 0 is ignored; this is a protocol violation that the bench flags.

Reset
REQ-028 While reset is 0, the following outputs are 0: imem_req_valid, instr_valid, instr, instr_pc.
REQ-029 While reset is 0, imem_addr = RESET_PC, and the internal state is cleared: fetch_pc = resp_pc = RESET_PC, occupancy = outstanding = drop_cnt = 0.
REQ-030 On reset assertion mid-operation, all in-flight state is discarded immediately; the first request after release is to RESET_PC, one cycle after release at the earliest.

Configuration
REQ-031 With macro FETCH_BYPASS_EN defined, a usable response arriving with an empty buffer, drop_cnt = 0 and no redirect is presented the same cycle:
- instr = imem_resp_data and instr_valid = 1;
- if instr_ready is 1, the response is consumed without a buffer write.
REQ-032 Without FETCH_BYPASS_EN, instructions are always presented from the buffer; the minimum response-to-instr_valid latency is 1 cycle.

Verification
REQ-033 Reset release, imem_req_ready=1, memory latency 1, instr_ready=1 -> requests to 0x0, 0x4, 0x8...; instr_pc sequence 0x0, 0x4, 0x8 with matching data.
REQ-034 DEPTH=4, instr_ready=0 -> exactly 4 requests issue, then imem_req_valid=0; after 4 responses, instr_valid=1 and occupancy=4.
REQ-035 Three requests outstanding, redirect_pc=0x100 -> those 3 responses are dropped; next imem_addr=0x100; first instr_pc=0x100.
REQ-036 Redirect on the same cycle as a response and a pop -> the pop completes, the response is discarded, and the buffer is empty next cycle.
REQ-037 fetch_pc=0xFFFF_FFFC, one request fires -> next imem_addr=0x0000_0000.
REQ-038 FETCH_BYPASS_EN on, empty buffer, response 0x0000_0013 -> instr=0x0000_0013 with instr_valid=1 in the same cycle; with the macro off, this appears 1 cycle later.
